// File: rtl/booth_mac_unit.sv
// Radix-4 Booth multiply / multiply-accumulate unit that owns the HI/LO registers.
// MADD/MSUB are built only when BOOTH_MAC_ACC_EN is defined; otherwise every op behaves as MULT.
module booth_mac_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         is_signed,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         hi_wr,
  input  logic         lo_wr,
  input  logic [W-1:0] hilo_wdata,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int U  = W + 4;
  localparam int PW = U + W;
  localparam int CW = $clog2(W/2 + 1);

  typedef enum logic [1:0] {IDLE, ITER, FIX, WB} state_t;

  state_t          state, next_state;
  logic            accept;
  logic [W+1:0]    mcand;
  logic [W+2:0]    mq;
  logic [PW-1:0]   prod;
  logic [CW-1:0]   cnt;
  logic [2:0]      trip;
  logic [U-1:0]    m_ext, mag, pp, upper, sum;
  logic            neg;
  logic [2*W-1:0]  p_full, hilo_next;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept     = 1'b1;
        next_state = ITER;
      end
      ITER:    if (cnt == '0) next_state = FIX;
      FIX:     next_state = WB;
      WB:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Triplet always sits in mq[2:0]; after W/2 shifts it is {bext, bext, b[W-1]} for FIX.
  assign trip  = mq[2:0];
  assign m_ext = {{2{mcand[W+1]}}, mcand};

  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (trip)
      3'b001, 3'b010: mag = m_ext;
      3'b011:         mag = {m_ext[U-2:0], 1'b0};
      3'b100: begin
        mag = {m_ext[U-2:0], 1'b0};
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        mag = m_ext;
        neg = 1'b1;
      end
      default: ;
    endcase
  end

  assign pp     = neg ? ~mag : mag;
  assign upper  = prod[PW-1:W];
  assign sum    = upper + pp + {{(U-1){1'b0}}, neg};
  assign p_full = prod[2*W-1:0];

`ifdef BOOTH_MAC_ACC_EN
  logic [1:0] op_q;

  always_ff @(posedge clk) begin
    if (reset)       op_q <= 2'b00;
    else if (accept) op_q <= op;
  end

  always_comb begin
    case (op_q)
      2'b01:   hilo_next = {hi, lo} + p_full;
      2'b10:   hilo_next = {hi, lo} - p_full;
      default: hilo_next = p_full;
    endcase
  end
`else
  logic unused_op;
  assign unused_op = ^op;
  assign hilo_next = p_full;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      prod  <= '0;
      mcand <= '0;
      mq    <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= (state == WB);
      case (state)
        IDLE: begin
          if (hi_wr) hi <= hilo_wdata;
          if (lo_wr) lo <= hilo_wdata;
          if (accept) begin
            mcand <= {{2{is_signed & a[W-1]}}, a};
            mq    <= {{2{is_signed & b[W-1]}}, b, 1'b0};
            prod  <= '0;
            cnt   <= CW'(W/2 - 1);
          end
        end
        ITER: begin
          prod <= {{2{sum[U-1]}}, sum, prod[W-1:2]};
          mq   <= {2'b00, mq[W+2:2]};
          cnt  <= cnt - 1'b1;
        end
        // Last digit lands at weight 2^W without a shift, so the low W bits are final.
        FIX: prod <= {sum, prod[W-1:0]};
        WB:  {hi, lo} <= hilo_next;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mac_unit.sv
// Directed bench for booth_mac_unit: W=32 and W=8 instances, hand-computed results.
// Accumulate expectations follow BOOTH_MAC_ACC_EN.
module tb_booth_mac_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start32, sgn32, hi_wr32, lo_wr32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, wd32;
  logic        busy32, done32;
  logic [31:0] hi32, lo32;
  logic        start8, sgn8, hi_wr8, lo_wr8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wd8;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int n_cmp = 0;
  int n_err = 0;
  int lat;
  int pulses;
  logic [31:0] prev_hi, exp_lo_madd, exp_hi_msub, exp_lo_msub;

  always #5 clk = ~clk;

  booth_mac_unit #(.W(32)) u32 (
    .clk(clk), .reset(reset), .start(start32), .is_signed(sgn32), .op(op32),
    .a(a32), .b(b32), .hi_wr(hi_wr32), .lo_wr(lo_wr32), .hilo_wdata(wd32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );

  booth_mac_unit #(.W(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .is_signed(sgn8), .op(op8),
    .a(a8), .b(b8), .hi_wr(hi_wr8), .lo_wr(lo_wr8), .hilo_wdata(wd8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_32(input logic sgn, input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
    start32 = 1'b1; sgn32 = sgn; op32 = o; a32 = av; b32 = bv;
    tick();
    start32 = 1'b0; a32 = ~av; b32 = ~bv; sgn32 = ~sgn; op32 = 2'b11;
  endtask

  task automatic start_8(input logic sgn, input logic [7:0] av, input logic [7:0] bv);
    start8 = 1'b1; sgn8 = sgn; op8 = 2'b00; a8 = av; b8 = bv;
    tick();
    start8 = 1'b0; a8 = ~av; b8 = ~bv; sgn8 = ~sgn;
  endtask

  task automatic wait_32(input int from, output int l);
    l = from;
    while (done32 !== 1'b1 && l < 60) begin
      tick();
      l++;
    end
  endtask

  task automatic wait_8(input int from, output int l);
    l = from;
    while (done8 !== 1'b1 && l < 30) begin
      tick();
      l++;
    end
  endtask

  initial begin
`ifdef BOOTH_MAC_ACC_EN
    exp_lo_madd = 32'h0000000B;
    exp_hi_msub = 32'hFFFFFFFF;
    exp_lo_msub = 32'hFFFFFFFF;
`else
    exp_lo_madd = 32'h00000006;
    exp_hi_msub = 32'h00000000;
    exp_lo_msub = 32'h00000001;
`endif
    reset = 1'b1;
    start32 = 0; sgn32 = 0; op32 = 0; a32 = 0; b32 = 0; hi_wr32 = 0; lo_wr32 = 0; wd32 = 0;
    start8 = 0; sgn8 = 0; op8 = 0; a8 = 0; b8 = 0; hi_wr8 = 0; lo_wr8 = 0; wd8 = 0;

    // 1: reset then idle
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t1_rst_busy", busy32, 0);
      chk("t1_rst_done", done32, 0);
      chk("t1_rst_hilo", {hi32, lo32}, 64'h0);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_idle_busy", busy32, 0);
      chk("t1_idle_done", done32, 0);
      chk("t1_idle_hilo", {hi32, lo32}, 64'h0);
      chk("t1_idle_w8", {busy8, done8, hi8, lo8}, 64'h0);
    end

    // 2: signed -3 * 7
    start_32(1'b1, 2'b00, 32'hFFFFFFFD, 32'd7);
    chk("t2_busy", busy32, 1);
    wait_32(0, lat);
    chk("t2_latency", 64'(lat), 64'd18);
    chk("t2_hi", hi32, 32'hFFFFFFFF);
    chk("t2_lo", lo32, 32'hFFFFFFEB);
    chk("t2_busy_done", busy32, 0);
    tick();
    chk("t2_done_pulse", done32, 0);

    // 3: all-ones unsigned / signed, and extreme signed operands
    start_32(1'b0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_32(0, lat);
    chk("t3_u_latency", 64'(lat), 64'd18);
    chk("t3_u_hilo", {hi32, lo32}, 64'hFFFFFFFE_00000001);
    start_32(1'b1, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_32(0, lat);
    chk("t3_s_hilo", {hi32, lo32}, 64'h00000000_00000001);
    start_32(1'b1, 2'b00, 32'h7FFFFFFF, 32'h80000000);
    wait_32(0, lat);
    chk("t3_s_max_min", {hi32, lo32}, 64'hC0000000_80000000);

    // 4: MTLO/MTHI, MADD, MSUB with a write in the start cycle
    lo_wr32 = 1'b1; wd32 = 32'd5;
    tick();
    lo_wr32 = 1'b0; hi_wr32 = 1'b1; wd32 = 32'd0;
    tick();
    hi_wr32 = 1'b0;
    chk("t4_mtlo", lo32, 32'd5);
    chk("t4_mthi", hi32, 32'd0);
    start_32(1'b1, 2'b01, 32'd2, 32'd3);
    wait_32(0, lat);
    chk("t4_madd_latency", 64'(lat), 64'd18);
    chk("t4_madd_lo", lo32, exp_lo_madd);
    chk("t4_madd_hi", hi32, 32'd0);
    hi_wr32 = 1'b1; lo_wr32 = 1'b1; wd32 = 32'd0;
    start_32(1'b1, 2'b10, 32'd1, 32'd1);
    hi_wr32 = 1'b0; lo_wr32 = 1'b0; wd32 = 32'h55555555;
    wait_32(0, lat);
    chk("t4_msub_hi", hi32, exp_hi_msub);
    chk("t4_msub_lo", lo32, exp_lo_msub);
    prev_hi = exp_hi_msub;

    // 5a: start and MTHI while busy are ignored
    start_32(1'b0, 2'b00, 32'd1000, 32'd1000);
    tick();
    tick();
    start32 = 1'b1; a32 = 32'd5; b32 = 32'd5; hi_wr32 = 1'b1; wd32 = 32'hDEADBEEF;
    tick();
    start32 = 1'b0; hi_wr32 = 1'b0;
    chk("t5_hi_hold", hi32, prev_hi);
    chk("t5_busy", busy32, 1);
    wait_32(3, lat);
    chk("t5_latency", 64'(lat), 64'd18);
    chk("t5_hilo", {hi32, lo32}, 64'h00000000_000F4240);

    // 5b: reset mid-operation aborts it
    start_32(1'b1, 2'b00, 32'd7, 32'd9);
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_rst_busy", busy32, 0);
    chk("t5_rst_done", done32, 0);
    chk("t5_rst_hilo", {hi32, lo32}, 64'h0);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done32 === 1'b1) pulses++;
    end
    chk("t5_no_done", 64'(pulses), 64'd0);
    start_32(1'b1, 2'b00, 32'hFFFFFFFE, 32'h40000000);
    wait_32(0, lat);
    chk("t5_fresh_latency", 64'(lat), 64'd18);
    chk("t5_fresh_hilo", {hi32, lo32}, 64'hFFFFFFFF_80000000);

    // 6: W=8 instance, back-to-back start in the done cycle
    start_8(1'b1, 8'h80, 8'h80);
    wait_8(0, lat);
    chk("t6_latency", 64'(lat), 64'd6);
    chk("t6_hilo", {hi8, lo8}, 64'h4000);
    start_8(1'b1, 8'h03, 8'hFB);
    chk("t6_b2b_busy", busy8, 1);
    chk("t6_b2b_done", done8, 0);
    wait_8(0, lat);
    chk("t6_b2b_latency", 64'(lat), 64'd6);
    chk("t6_b2b_hilo", {hi8, lo8}, 64'hFFF1);
    start_8(1'b0, 8'hFF, 8'hFF);
    wait_8(0, lat);
    chk("t6_u_ones", {hi8, lo8}, 64'hFE01);
    start_8(1'b0, 8'hC8, 8'h64);
    wait_8(0, lat);
    chk("t6_u_200x100", {hi8, lo8}, 64'h4E20);
    start_8(1'b1, 8'h7F, 8'h81);
    wait_8(0, lat);
    chk("t6_s_127xm127", {hi8, lo8}, 64'hC0FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
